// File: rtl/instruction_prefetcher_pkg.sv
// Shared types, derived-width helpers and byte selection for the instruction prefetcher.
package instruction_prefetcher_pkg;

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_WAIT   = 1'b1
  } fetch_state_e;

  localparam int unsigned MAX_DATA_BITS = 1024;

  // Number of byte-offset bits in a PC for a given memory word width.
  function automatic int unsigned off_bits(input int unsigned data_bits);
    return $clog2(data_bits / 8);
  endfunction

  // Byte k of a word; the most significant byte sits at the lowest PC.
  function automatic logic [7:0] select_byte(input logic [MAX_DATA_BITS-1:0] word,
                                             input int unsigned bytes,
                                             input int unsigned k);
    logic [MAX_DATA_BITS-1:0] shifted;
    shifted = word >> (8 * (bytes - 1 - k));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/instruction_byte_queue.sv
// Circular FIFO of {byte, pc} entries with flush and simultaneous push/pop.
module instruction_byte_queue #(
  parameter  int unsigned WIDTH    = 17,
  parameter  int unsigned DEPTH    = 4,
  localparam int unsigned PTR_BITS = $clog2(DEPTH),
  localparam int unsigned CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0]    slots [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/instruction_prefetcher.sv
// Byte-stream instruction prefetcher: one-word line buffer feeding a byte queue.
module instruction_prefetcher
  import instruction_prefetcher_pkg::*;
#(
  parameter  int unsigned ADDR_BITS   = 8,
  parameter  int unsigned DATA_BITS   = 16,
  parameter  int unsigned QUEUE_DEPTH = 4,
  parameter  int unsigned RESET_PC    = 0,
  localparam int unsigned BYTES       = DATA_BITS / 8,
  localparam int unsigned OFF         = off_bits(DATA_BITS),
  localparam int unsigned PC_BITS     = ADDR_BITS + OFF
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_BITS-1:0] programAddress,
  input  logic [DATA_BITS-1:0] programDataOut,
  input  logic                 redirect,
  input  logic [PC_BITS-1:0]   redirectPc,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [7:0]           instruction,
  output logic [PC_BITS-1:0]   instrPc,
  output logic [PC_BITS-1:0]   fetchPc
);

  localparam int unsigned ENTRY_BITS = 8 + PC_BITS;
  localparam int unsigned CNT_BITS   = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e           state, state_next;
  logic [PC_BITS-1:0]     fetch_pc, fetch_pc_next;
  logic                   line_valid, line_valid_next;
  logic [ADDR_BITS-1:0]   line_addr, line_addr_next;
  logic [DATA_BITS-1:0]   line_data, line_data_next;
  logic [ADDR_BITS-1:0]   wait_addr, wait_addr_next;
  logic                   push;
  logic [7:0]             push_byte;
  logic [CNT_BITS-1:0]    count;
  logic                   hit, deq, space;
  int unsigned            byte_idx;

  assign programAddress = ADDR_BITS'(fetch_pc >> OFF);
  assign fetchPc        = fetch_pc;
  assign byte_idx       = 32'(fetch_pc % PC_BITS'(BYTES));
  assign hit            = line_valid && (line_addr == programAddress);
  assign instrValid     = (count != '0);
  assign deq            = instrValid && instrReady;
  assign space          = (count < CNT_BITS'(QUEUE_DEPTH)) || deq;

  // State register, fetch PC and line buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_STREAM;
      fetch_pc   <= PC_BITS'(RESET_PC);
      line_valid <= 1'b0;
      line_addr  <= '0;
      line_data  <= '0;
      wait_addr  <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      line_valid <= line_valid_next;
      line_addr  <= line_addr_next;
      line_data  <= line_data_next;
      wait_addr  <= wait_addr_next;
    end
  end

  // Next-state, line-buffer refill and enqueue decisions.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    line_valid_next = line_valid;
    line_addr_next  = line_addr;
    line_data_next  = line_data;
    wait_addr_next  = wait_addr;
    push            = 1'b0;
    push_byte       = select_byte(MAX_DATA_BITS'(line_data), BYTES, byte_idx);
    case (state)
      ST_STREAM: begin
        if (redirect) begin
          fetch_pc_next = redirectPc;
        end else if (space) begin
          // A full queue stalls here so no read is issued until room appears.
          if (hit) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc + PC_BITS'(1);
          end else begin
            wait_addr_next = programAddress;
            state_next     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The in-flight read always lands in the line buffer, even on redirect.
        line_valid_next = 1'b1;
        line_addr_next  = wait_addr;
        line_data_next  = programDataOut;
        push_byte       = select_byte(MAX_DATA_BITS'(programDataOut), BYTES, byte_idx);
        state_next      = ST_STREAM;
        if (redirect) begin
          fetch_pc_next = redirectPc;
        end else if (space) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + PC_BITS'(1);
        end
      end
      default: state_next = ST_STREAM;
    endcase
  end

  instruction_byte_queue #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({push_byte, fetch_pc}),
    .pop       (deq),
    .head      ({instruction, instrPc}),
    .count     (count)
  );

endmodule
